// File: rtl/dma.sv
// dma: four-channel 8237-style DMA controller.
// Moves bytes IO<->memory or memory->memory over the shared bus.
module dma (
   input  logic        clk,
   input  logic        Reset,
   input  logic        CS,
   input  logic        HLDA,
   input  logic [3:0]  DREQ,
   output logic        HRQ,
   output logic [3:0]  DACK,
   output logic        AEN,
   output logic        EOP,
   output logic        IOflag,
   inout  wire         IReady,
   inout  wire         TReady,
   inout  wire         MEMWR,
   inout  wire         IOR,
   inout  wire         IOW,
   inout  wire  [15:0] Address_Bus,
   inout  wire  [7:0]  Data_Bus
);

   typedef enum logic [2:0] {
      IDLE, REQ, GRANT, XFER, MM_RD, MM_WR, DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [15:0] ch_addr [4];
   logic [15:0] ch_cnt  [4];
   logic [3:0]  mode;
   logic [3:0]  mask;
   logic        mm_en;
   logic        ctl_en;
   logic        mm_go;
   logic [7:0]  tmp;
   logic [1:0]  chan;
   logic        mm;
   logic        gap;

   logic [3:0]  req_ok;
   logic [1:0]  pick;
   logic        mm_ok;
   logic        wr_en;
   logic [4:0]  idx;
   logic        io_done;
   logic        mm_rd_done;
   logic        mm_wr_done;

   logic        ir_d;
   logic        mw_d;
   logic        rd_d;
   logic        wr_d;
   logic [15:0] ab_d;
   logic        db_en;

   // eligible requests and fixed priority, channel 0 first
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         req_ok[n] = DREQ[n] & ~mask[n] & ctl_en
                   & (ch_cnt[n] != 16'd0);
      end
      pick = 2'd0;
      priority casez (req_ok)
         4'b???1: pick = 2'd0;
         4'b??10: pick = 2'd1;
         4'b?100: pick = 2'd2;
         4'b1000: pick = 2'd3;
         default: pick = 2'd0;
      endcase
   end

   assign mm_ok = mm_go & mm_en & ctl_en & (ch_cnt[0] != 16'd0);
   assign wr_en = ~AEN & ~CS & IOW;
   assign idx   = Address_Bus[4:0];

   assign io_done    = (state == XFER) & HLDA & ~gap & TReady;
   assign mm_rd_done = (state == MM_RD) & HLDA & TReady;
   assign mm_wr_done = (state == MM_WR) & HLDA & TReady;

   // state register
   always_ff @(posedge clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state and bus outputs
   always_comb begin
      state_nxt = state;
      HRQ    = 1'b0;
      AEN    = 1'b0;
      DACK   = 4'b0000;
      EOP    = 1'b0;
      IOflag = 1'b0;
      ir_d   = 1'b0;
      mw_d   = 1'b0;
      rd_d   = 1'b0;
      wr_d   = 1'b0;
      ab_d   = ch_addr[chan];
      db_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (mm_ok || (|req_ok)) state_nxt = REQ;
         end
         REQ: begin
            HRQ = 1'b1;
            if (HLDA) state_nxt = GRANT;
         end
         GRANT: begin
            HRQ = 1'b1;
            AEN = 1'b1;
            if (mm) begin
               ab_d = ch_addr[0];
               state_nxt = MM_RD;
            end else begin
               DACK[chan] = 1'b1;
               IOflag = mode[chan];
               ir_d = 1'b1;
               mw_d = mode[chan];
               rd_d = mode[chan];
               wr_d = ~mode[chan];
               state_nxt = XFER;
            end
            if (!HLDA) state_nxt = IDLE;
         end
         XFER: begin
            HRQ = 1'b1;
            AEN = 1'b1;
            DACK[chan] = 1'b1;
            IOflag = mode[chan];
            ir_d = ~gap;
            mw_d = mode[chan];
            rd_d = mode[chan];
            wr_d = ~mode[chan];
            if (!HLDA) begin
               state_nxt = IDLE;
            end else if (io_done) begin
               if (ch_cnt[chan] == 16'd1) state_nxt = DONE;
               else if (DREQ[chan])       state_nxt = XFER;
               else                       state_nxt = IDLE;
            end
         end
         MM_RD: begin
            HRQ = 1'b1;
            AEN = 1'b1;
            ab_d = ch_addr[0];
            ir_d = 1'b1;
            if (!HLDA)       state_nxt = IDLE;
            else if (TReady) state_nxt = MM_WR;
         end
         MM_WR: begin
            HRQ = 1'b1;
            AEN = 1'b1;
            ab_d = ch_addr[1];
            db_en = 1'b1;
            mw_d = 1'b1;
            ir_d = 1'b1;
            if (!HLDA) begin
               state_nxt = IDLE;
            end else if (TReady) begin
               if (ch_cnt[0] == 16'd1) state_nxt = DONE;
               else                    state_nxt = MM_RD;
            end
         end
         DONE: begin
            EOP = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // programming registers, channel bookkeeping and transfer progress
   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int n = 0; n < 4; n++) begin
            ch_addr[n] <= 16'd0;
            ch_cnt[n]  <= 16'd0;
         end
         mode   <= 4'd0;
         mask   <= 4'd0;
         mm_en  <= 1'b0;
         ctl_en <= 1'b0;
         mm_go  <= 1'b0;
         tmp    <= 8'd0;
         chan   <= 2'd0;
         mm     <= 1'b0;
         gap    <= 1'b0;
      end else begin
         gap <= io_done & (ch_cnt[chan] != 16'd1) & DREQ[chan];
         if (state == IDLE) begin
            mm_go <= 1'b0;
            if (mm_ok) begin
               mm   <= 1'b1;
               chan <= 2'd0;
            end else if (|req_ok) begin
               mm   <= 1'b0;
               chan <= pick;
            end
         end
         if (io_done) begin
            ch_addr[chan] <= ch_addr[chan] + 16'd1;
            ch_cnt[chan]  <= ch_cnt[chan] - 16'd1;
         end
         if (mm_rd_done) tmp <= Data_Bus;
         if (mm_wr_done) begin
            ch_addr[0] <= ch_addr[0] + 16'd1;
            ch_addr[1] <= ch_addr[1] + 16'd1;
            ch_cnt[0]  <= ch_cnt[0] - 16'd1;
         end
         if (wr_en) begin
            unique case (1'b1)
               (idx[4] == 1'b0): begin
                  unique case (idx[1:0])
                     2'd0: ch_addr[idx[3:2]][7:0]  <= Data_Bus;
                     2'd1: ch_addr[idx[3:2]][15:8] <= Data_Bus;
                     2'd2: ch_cnt[idx[3:2]][7:0]   <= Data_Bus;
                     2'd3: ch_cnt[idx[3:2]][15:8]  <= Data_Bus;
                     default: ;
                  endcase
               end
               (idx == 5'h10): begin
                  mm_en  <= Data_Bus[0];
                  ctl_en <= Data_Bus[1];
                  mm_go  <= Data_Bus[2];
               end
               (idx >= 5'h11 && idx <= 5'h14): begin
                  mode[idx[1:0] - 2'd1] <= Data_Bus[0];
               end
               (idx == 5'h15): mask <= Data_Bus[3:0];
               default: ;
            endcase
         end
      end
   end

   // bus drivers, released whenever the CPU owns the bus
   assign IReady      = AEN ? ir_d : 1'bz;
   assign MEMWR       = AEN ? mw_d : 1'bz;
   assign IOR         = AEN ? rd_d : 1'bz;
   assign IOW         = AEN ? wr_d : 1'bz;
   assign Address_Bus = AEN ? ab_d : 16'hzzzz;
   assign Data_Bus    = db_en ? tmp : 8'hzz;

endmodule

// File: tb/tb_dma.sv
// tb_dma: directed bench for the dma controller.
// Programs channels over the bus and checks grants and addresses.
module tb_dma;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        CS = 1'b1;
   logic        HLDA = 1'b0;
   logic [3:0]  DREQ = 4'd0;
   logic        HRQ;
   logic [3:0]  DACK;
   logic        AEN;
   logic        EOP;
   logic        IOflag;
   wire         IReady;
   wire         TReady;
   wire         MEMWR;
   wire         IOR;
   wire         IOW;
   wire  [15:0] Address_Bus;
   wire  [7:0]  Data_Bus;

   logic        tb_iow = 1'b0;
   logic        tready = 1'b0;
   logic [15:0] tb_a = 16'd0;
   logic [7:0]  tb_d = 8'd0;

   int total = 0;
   int bad = 0;

   assign TReady      = tready;
   assign IOW         = AEN ? 1'bz : tb_iow;
   assign IOR         = AEN ? 1'bz : 1'b0;
   assign Address_Bus = AEN ? 16'hzzzz : tb_a;
   assign Data_Bus    = AEN ? 8'hzz : tb_d;

   dma dut (
      .clk(clk), .Reset(Reset), .CS(CS), .HLDA(HLDA),
      .DREQ(DREQ), .HRQ(HRQ), .DACK(DACK), .AEN(AEN),
      .EOP(EOP), .IOflag(IOflag), .IReady(IReady),
      .TReady(TReady), .MEMWR(MEMWR), .IOR(IOR), .IOW(IOW),
      .Address_Bus(Address_Bus), .Data_Bus(Data_Bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [4:0] i, input logic [7:0] v);
      tb_a = {11'd0, i};
      tb_d = v;
      CS = 1'b0;
      tb_iow = 1'b1;
      tick();
      CS = 1'b1;
      tb_iow = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_hrq", HRQ, 0);
      chk("rst_aen", AEN, 0);
      chk("rst_dack", DACK, 0);
      chk("rst_eop", EOP, 0);
      Reset = 1'b0;

      // memory to memory: 3 bytes 0x0100 -> 0x2000
      wr(5'h00, 8'h00); wr(5'h01, 8'h01);
      wr(5'h02, 8'h03); wr(5'h03, 8'h00);
      wr(5'h04, 8'h00); wr(5'h05, 8'h20);
      wr(5'h10, 8'h03);
      HLDA = 1'b1;
      tready = 1'b1;
      wr(5'h10, 8'h07);
      tick();
      chk("mm_hrq", HRQ, 1);
      chk("mm_req_aen", AEN, 0);
      tick();
      chk("mm_grant_aen", AEN, 1);
      chk("mm_grant_dack", DACK, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mm_rd_addr", Address_Bus, 32'h0100 + k);
         chk("mm_rd_memwr", MEMWR, 0);
         chk("mm_rd_irdy", IReady, 1);
         tick();
         chk("mm_wr_addr", Address_Bus, 32'h2000 + k);
         chk("mm_wr_memwr", MEMWR, 1);
      end
      tick();
      chk("mm_eop", EOP, 1);
      chk("mm_done_hrq", HRQ, 0);
      chk("mm_done_aen", AEN, 0);
      tick();
      chk("mm_eop_low", EOP, 0);
      chk("mm_cnt0", dut.ch_cnt[0], 0);
      chk("mm_addr0", dut.ch_addr[0], 32'h0103);
      chk("mm_addr1", dut.ch_addr[1], 32'h2003);

      // IO to memory on channel 2, address 600, 2 bytes
      wr(5'h08, 8'h58); wr(5'h09, 8'h02);
      wr(5'h0A, 8'h02); wr(5'h0B, 8'h00);
      wr(5'h13, 8'h01);
      wr(5'h10, 8'h02);
      DREQ = 4'b0100;
      tick();
      chk("io_hrq", HRQ, 1);
      chk("io_req_aen", AEN, 0);
      tick();
      chk("io_dack", DACK, 4'b0100);
      chk("io_flag", IOflag, 1);
      chk("io_memwr", MEMWR, 1);
      chk("io_ior", IOR, 1);
      chk("io_addr0", Address_Bus, 600);
      chk("io_irdy", IReady, 1);
      tick();
      chk("io_xfer_addr", Address_Bus, 600);
      tick();
      chk("io_gap_irdy", IReady, 0);
      chk("io_gap_addr", Address_Bus, 601);
      tick();
      chk("io_b2_irdy", IReady, 1);
      tick();
      chk("io_eop", EOP, 1);
      chk("io_done_hrq", HRQ, 0);
      chk("io_done_dack", DACK, 0);
      DREQ = 4'b0000;
      tick();
      chk("io_eop_low", EOP, 0);
      chk("io_cnt2", dut.ch_cnt[2], 0);
      chk("io_addr2", dut.ch_addr[2], 602);

      // priority: ch2 before ch3
      wr(5'h08, 8'h00); wr(5'h09, 8'h03);
      wr(5'h0A, 8'h01);
      wr(5'h0C, 8'h00); wr(5'h0D, 8'h04);
      wr(5'h0E, 8'h01); wr(5'h0F, 8'h00);
      wr(5'h14, 8'h00);
      DREQ = 4'b1100;
      tick();
      tick();
      chk("pri_dack2", DACK, 4'b0100);
      chk("pri_addr2", Address_Bus, 32'h0300);
      tick();
      tick();
      chk("pri_eop2", EOP, 1);
      tick();
      chk("pri_idle_hrq", HRQ, 0);
      tick();
      chk("pri_hrq3", HRQ, 1);
      tick();
      chk("pri_dack3", DACK, 4'b1000);
      chk("pri_addr3", Address_Bus, 32'h0400);
      chk("pri_memwr3", MEMWR, 0);
      chk("pri_flag3", IOflag, 0);
      chk("pri_iow3", IOW, 1);
      tick();
      tick();
      chk("pri_eop3", EOP, 1);
      DREQ = 4'b0000;
      tick();

      // DREQ drop after first of 4 bytes, then resume
      wr(5'h08, 8'h00); wr(5'h09, 8'h05);
      wr(5'h0A, 8'h04);
      DREQ = 4'b0100;
      tick();
      tick();
      tick();
      DREQ = 4'b0000;
      tick();
      chk("drop_hrq", HRQ, 0);
      chk("drop_eop", EOP, 0);
      chk("drop_cnt", dut.ch_cnt[2], 3);
      DREQ = 4'b0100;
      tick();
      tick();
      chk("resume_addr", Address_Bus, 32'h0501);

      // HLDA lost in XFER: abort, byte not counted
      tick();
      HLDA = 1'b0;
      tick();
      chk("abort_aen", AEN, 0);
      chk("abort_eop", EOP, 0);
      chk("abort_cnt", dut.ch_cnt[2], 3);
      chk("abort_addr", dut.ch_addr[2], 32'h0501);
      tick();
      chk("rereq_hrq", HRQ, 1);
      chk("rereq_aen", AEN, 0);

      // reset while waiting in XFER
      HLDA = 1'b1;
      tick();
      tick();
      tready = 1'b0;
      tick();
      chk("wait_aen", AEN, 1);
      chk("wait_cnt", dut.ch_cnt[2], 3);
      Reset = 1'b1;
      tick();
      chk("mid_rst_hrq", HRQ, 0);
      chk("mid_rst_aen", AEN, 0);
      chk("mid_rst_eop", EOP, 0);
      chk("mid_rst_cnt", dut.ch_cnt[2], 0);
      Reset = 1'b0;
      DREQ = 4'b0000;
      tready = 1'b1;

      // zero count and masked channels are not serviced
      wr(5'h10, 8'h02);
      DREQ = 4'b0001;
      tick();
      tick();
      chk("zero_cnt_hrq", HRQ, 0);
      DREQ = 4'b0000;
      wr(5'h15, 8'h02);
      wr(5'h06, 8'h01);
      DREQ = 4'b0010;
      tick();
      tick();
      chk("mask_hrq", HRQ, 0);
      wr(5'h15, 8'h00);
      tick();
      chk("unmask_hrq", HRQ, 1);
      tick();
      chk("unmask_dack", DACK, 4'b0010);
      DREQ = 4'b0000;
      tick();
      tick();
      chk("unmask_eop", EOP, 1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
